// File: rtl/scan_sel_ctrl.sv
// Channel-select sequencer for a 2-to-4 decoder: scans the enabled channels,
// holding each for a dwell window with a blanking gap around every switch.
module scan_sel_ctrl #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         ch_mask,
  output logic               en,
  output logic               a,
  output logic               b,
  output logic               chan_done,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYC);

  state_t             state_q, state_d;
  logic [3:0]         blank_cnt_q, blank_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]         addr_q, addr_d;
  logic               en_q, en_d;
  logic               chan_done_q, chan_done_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;

  logic [1:0]         first_idx;
  logic [1:0]         next_idx;
  logic [1:0]         cand_idx;
  logic               next_wrap;
  logic               mask_any;
  logic [DWELL_W-1:0] dwell_eff;

  // Searching offsets from far to near lets the nearest enabled channel win;
  // offset 4 is the current channel itself, covering the single-channel case.
  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_mask[i]) first_idx = 2'(i);
    end
    next_idx = addr_q;
    cand_idx = addr_q;
    for (int off = 4; off >= 1; off--) begin
      cand_idx = addr_q + 2'(off);
      if (ch_mask[cand_idx]) next_idx = cand_idx;
    end
    next_wrap = (next_idx <= addr_q);
    mask_any  = (ch_mask != 4'd0);
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  end

  always_comb begin
    state_d      = state_q;
    blank_cnt_d  = blank_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    addr_d       = addr_q;
    en_d         = en_q;
    chan_done_d  = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = 1'b1;
        if (run && mask_any) begin
          addr_d      = first_idx;
          blank_cnt_d = BLANK_INIT;
          state_d     = BLANK;
        end
      end
      BLANK: begin
        en_d = 1'b1;
        if (!run) begin
          state_d = IDLE;
        end else if (blank_cnt_q <= 4'd1) begin
          dwell_cnt_d = dwell_eff;
          en_d        = 1'b0;
          state_d     = ACTIVE;
        end else begin
          blank_cnt_d = blank_cnt_q - 4'd1;
        end
      end
      ACTIVE: begin
        if (dwell_cnt_q <= DWELL_W'(1)) begin
          en_d         = 1'b1;
          chan_done_d  = 1'b1;
          frame_done_d = mask_any && next_wrap;
          if (run && mask_any) begin
            addr_d      = next_idx;
            blank_cnt_d = BLANK_INIT;
            state_d     = BLANK;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        en_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      blank_cnt_q  <= 4'd0;
      dwell_cnt_q  <= '0;
      addr_q       <= 2'd0;
      en_q         <= 1'b1;
      chan_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      blank_cnt_q  <= blank_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      addr_q       <= addr_d;
      en_q         <= en_d;
      chan_done_q  <= chan_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign en         = en_q;
  assign a          = addr_q[1];
  assign b          = addr_q[0];
  assign chan_done  = chan_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Directed bench for scan_sel_ctrl: a monitor logs every active window and
// guards address stability and blanking; the main flow checks window records.
module tb_scan_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] dwell;
  logic [3:0] ch_mask;
  logic       en, a, b, chan_done, frame_done, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] addr;
    int         low;
    int         gap;
    logic       cd;
    logic       fd;
  } win_t;

  win_t wq[$];

  scan_sel_ctrl #(.DWELL_W(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .dwell      (dwell),
    .ch_mask    (ch_mask),
    .en         (en),
    .a          (a),
    .b          (b),
    .chan_done  (chan_done),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window monitor and safety guard
  logic       prev_en;
  int         high_run;
  int         low_run;
  int         gap_lat;
  logic [1:0] win_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en  = 1'b1;
      high_run = 0;
      low_run  = 0;
    end else begin
      if (en === 1'b0) begin
        if (prev_en) begin
          check("blank_gap", 32'(high_run >= 2), 1);
          gap_lat  = high_run;
          low_run  = 1;
          win_addr = {a, b};
        end else begin
          check("addr_stable", {30'd0, a, b}, {30'd0, win_addr});
          low_run++;
        end
        check("pulse_in_active", {30'd0, chan_done, frame_done}, 0);
      end else begin
        if (!prev_en) begin
          wq.push_back('{addr: win_addr, low: low_run, gap: gap_lat,
                         cd: chan_done, fd: frame_done});
          high_run = 1;
        end else begin
          check("stray_pulse", {30'd0, chan_done, frame_done}, 0);
          high_run++;
        end
      end
      prev_en = en;
    end
  end

  task automatic wait_wins(input int n, input int budget);
    int c = 0;
    while (wq.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check("win_timeout", 32'(wq.size() >= n), 1);
  endtask

  task automatic wait_en(input logic val, input int budget);
    int c = 0;
    while (en !== val && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check("en_timeout", {31'd0, en}, {31'd0, val});
  endtask

  task automatic expect_win(input string tag, input int addr, input int low,
                            input int gap, input logic fd);
    win_t w;
    if (wq.size() == 0) begin
      check({tag, "_missing"}, 0, 1);
    end else begin
      w = wq.pop_front();
      check({tag, "_addr"}, {30'd0, w.addr}, 32'(addr));
      check({tag, "_low"}, 32'(w.low), 32'(low));
      if (gap >= 0) check({tag, "_gap"}, 32'(w.gap), 32'(gap));
      check({tag, "_cd"}, {31'd0, w.cd}, 1);
      check({tag, "_fd"}, {31'd0, w.fd}, {31'd0, fd});
    end
  endtask

  task automatic stop_and_quiet(input string tag);
    run = 1'b0;
    @(negedge clk); #1;
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_en"}, {31'd0, en}, 1);
    repeat (10) @(negedge clk);
    #1;
    check({tag, "_quiet"}, 32'(wq.size()), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    run     = 1'b0;
    dwell   = 8'd0;
    ch_mask = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_en", {31'd0, en}, 1);
    check("rst_ab", {30'd0, a, b}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_cd", {31'd0, chan_done}, 0);
    check("rst_fd", {31'd0, frame_done}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Full scan; run is dropped in the BLANK after the fifth window
    ch_mask = 4'b1111; dwell = 8'd3; run = 1'b1;
    wait_wins(5, 200);
    run = 1'b0;
    expect_win("full0", 0, 3, -1, 1'b0);
    expect_win("full1", 1, 3, 2, 1'b0);
    expect_win("full2", 2, 3, 2, 1'b0);
    expect_win("full3", 3, 3, 2, 1'b1);
    expect_win("full4", 0, 3, 2, 1'b0);
    stop_and_quiet("full_stop");

    // Sparse mask 1010
    ch_mask = 4'b1010; dwell = 8'd2; run = 1'b1;
    wait_wins(3, 200);
    run = 1'b0;
    expect_win("sp0", 1, 2, -1, 1'b0);
    expect_win("sp1", 3, 2, 2, 1'b1);
    expect_win("sp2", 1, 2, 2, 1'b0);
    stop_and_quiet("sp_stop");

    // Single channel 10 repeats
    ch_mask = 4'b0100; dwell = 8'd1; run = 1'b1;
    wait_wins(3, 200);
    run = 1'b0;
    expect_win("one0", 2, 1, -1, 1'b1);
    expect_win("one1", 2, 1, 2, 1'b1);
    expect_win("one2", 2, 1, 2, 1'b1);
    stop_and_quiet("one_stop");

    // Dwell 0 acts as 1
    ch_mask = 4'b0001; dwell = 8'd0; run = 1'b1;
    wait_wins(1, 100);
    run = 1'b0;
    expect_win("dw0", 0, 1, -1, 1'b1);
    stop_and_quiet("dw0_stop");

    // Dwell 255
    ch_mask = 4'b0010; dwell = 8'd255; run = 1'b1;
    wait_wins(1, 600);
    run = 1'b0;
    expect_win("dw255", 1, 255, -1, 1'b1);
    stop_and_quiet("dw255_stop");

    // Dwell changed mid-window only affects the next channel
    ch_mask = 4'b0011; dwell = 8'd4; run = 1'b1;
    wait_en(1'b0, 50);
    @(negedge clk); #1;
    dwell = 8'd2;
    wait_wins(2, 100);
    run = 1'b0;
    expect_win("dwchg0", 0, 4, -1, 1'b0);
    expect_win("dwchg1", 1, 2, 2, 1'b1);
    stop_and_quiet("dwchg_stop");

    // Run dropped one cycle into a 4-cycle window
    ch_mask = 4'b0011; dwell = 8'd4; run = 1'b1;
    wait_en(1'b0, 50);
    @(negedge clk); #1;
    run = 1'b0;
    wait_wins(1, 50);
    check("midact_busy", {31'd0, busy}, 0);
    expect_win("midact", 0, 4, -1, 1'b0);
    stop_and_quiet("midact_stop");

    // Empty mask never starts
    ch_mask = 4'b0000; dwell = 8'd3; run = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("mask0_en", {31'd0, en}, 1);
    check("mask0_busy", {31'd0, busy}, 0);
    check("mask0_quiet", 32'(wq.size()), 0);
    run = 1'b0;

    // Asynchronous reset in the middle of an active window
    ch_mask = 4'b1111; dwell = 8'd8; run = 1'b1;
    wait_en(1'b0, 50);
    @(negedge clk); #3;
    check("arst_pre_en", {31'd0, en}, 0);
    rst_n = 1'b0;
    #1;
    check("arst_en", {31'd0, en}, 1);
    check("arst_ab", {30'd0, a, b}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("arst_quiet", 32'(wq.size()), 0);
    check("arst_busy_after", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
